// File: rtl/fb_pixel_writer.sv
// Pixel-write AXI4-Lite master: maps an (x, y, RGB565) request to one single-beat
// framebuffer write, clipping off-screen pixels and counting outcomes in `status`.
module fb_pixel_writer #(
    parameter logic [31:0] FB_BASE     = 32'h1000_0000,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned PIXEL_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fb_addr,
    input  logic [15:0] fb_data,
    input  logic        w_en,
    output logic [1:0]  axi_master_state,
    output logic        axi_master_writes_done,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] status
);

    localparam int unsigned COORD_W = 16;

    // IDLE must stay 2'b00: the drawer polls for it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q;
    logic                 w_en_q;
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;
    logic [15:0]          data_q;
    logic [31:0]          awaddr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 awvalid_q;
    logic                 wvalid_q;
    logic                 bready_q;
    logic                 done_q;
    logic [15:0]          pix_q;
    logic [7:0]           clip_q;
    logic [7:0]           err_q;

    logic                 clip_d;
    logic [31:0]          addr_d;
    logic [31:0]          wdata_d;
    logic [3:0]           wstrb_d;
    logic [7:0]           r8_d;
    logic [7:0]           g8_d;
    logic [7:0]           b8_d;
    logic                 aw_ok_d;
    logic                 w_ok_d;

    // Address, clip test and bus formatting for the latched pixel.
    always_comb begin
        clip_d  = (32'(x_q) >= H_RES) || (32'(y_q) >= V_RES);
        addr_d  = FB_BASE + ((32'(y_q) * 32'(H_RES)) + 32'(x_q)) * 32'(PIXEL_BYTES);
        r8_d    = {data_q[15:11], data_q[15:13]};
        g8_d    = {data_q[10:5],  data_q[10:9]};
        b8_d    = {data_q[4:0],   data_q[4:2]};
        wdata_d = {8'hFF, r8_d, g8_d, b8_d};
        wstrb_d = 4'b1111;
        if (PIXEL_BYTES == 2) begin
            wdata_d = {data_q, data_q};
            wstrb_d = addr_d[1] ? 4'b1100 : 4'b0011;
        end
        // A channel is finished once its VALID is low or is being accepted now.
        aw_ok_d = !awvalid_q || m_axi_awready;
        w_ok_d  = !wvalid_q  || m_axi_wready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            w_en_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            data_q    <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            pix_q     <= '0;
            clip_q    <= '0;
            err_q     <= '0;
        end else begin
            w_en_q <= w_en;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_en && !w_en_q) begin
                        x_q     <= fb_addr[31:16];
                        y_q     <= fb_addr[15:0];
                        data_q  <= fb_data;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (clip_d) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                        if (clip_q != '1) clip_q <= clip_q + 8'd1;
                    end else begin
                        awaddr_q  <= addr_d;
                        wdata_q   <= wdata_d;
                        wstrb_q   <= wstrb_d;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
                    if (aw_ok_d && w_ok_d) begin
                        bready_q <= 1'b1;
                        state_q  <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Errors are counted but never retried.
                    if (m_axi_bvalid && bready_q) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_IDLE;
                        if (pix_q != '1) pix_q <= pix_q + 16'd1;
                        if ((m_axi_bresp != 2'b00) && (err_q != '1)) err_q <= err_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign axi_master_state       = state_q;
    assign axi_master_writes_done = done_q;
    assign m_axi_awaddr           = awaddr_q;
    assign m_axi_awprot           = 3'b000;
    assign m_axi_awvalid          = awvalid_q;
    assign m_axi_wdata            = wdata_q;
    assign m_axi_wstrb            = wstrb_q;
    assign m_axi_wvalid           = wvalid_q;
    assign m_axi_bready           = bready_q;
    assign status                 = {pix_q, clip_q, err_q};

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: directed pixels against a configurable AXI slave,
// with a per-transaction reference model checked every cycle.
module tb_fb_pixel_writer;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int HR = 640;
    localparam int VR = 480;
    localparam int PB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fb_addr;
    logic [15:0] fb_data;
    logic        w_en;
    logic [1:0]  state;
    logic        done;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] status;

    always #5 clk = ~clk;

    fb_pixel_writer #(.FB_BASE(BASE), .H_RES(HR), .V_RES(VR), .PIXEL_BYTES(PB)) dut (
        .clk(clk), .rst_n(rst_n), .fb_addr(fb_addr), .fb_data(fb_data), .w_en(w_en),
        .axi_master_state(state), .axi_master_writes_done(done),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .status(status)
    );

    // Slave: AW accepted after aw_delay cycles of AWVALID, W at once, B one cycle after both.
    int   aw_delay;
    int   aw_wait;
    logic aw_seen, w_seen;
    logic [1:0] cur_bresp;

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid;
    assign bresp   = cur_bresp;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_wait <= 0; aw_seen <= 1'b0; w_seen <= 1'b0; bvalid <= 1'b0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
                bvalid <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                if (awvalid && awready) aw_seen <= 1'b1;
                if (wvalid && wready)   w_seen  <= 1'b1;
            end
        end
    end

    // Reference model: what each accepted pixel must produce.
    typedef struct {
        bit          clip;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  br;
    } exp_t;

    exp_t q[$];
    int   m_pix, m_clip, m_err;
    int   n_checks = 0, n_err = 0;
    int   aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, awv_cyc = 0, wv_cyc = 0;
    logic [31:0] cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    function automatic exp_t model(int x, int y, logic [15:0] c, logic [1:0] br);
        exp_t e;
        int r5, g6, b5;
        r5 = int'(c[15:11]); g6 = int'(c[10:5]); b5 = int'(c[4:0]);
        e.clip = (x >= HR) || (y >= VR);
        e.addr = BASE + 32'(y * HR + x) * 32'(PB);
        e.data = {8'hFF, 8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
        e.strb = 4'hF;
        e.br   = br;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    logic        prev_aw_pend, prev_w_pend;
    logic [31:0] prev_awaddr, prev_wdata;
    exp_t        hd;

    always @(negedge clk) begin
        if (awvalid && awready) aw_hs_cnt++;
        if (wvalid && wready)   w_hs_cnt++;
        if (bvalid && bready)   b_hs_cnt++;
        if (awvalid) awv_cyc++;
        if (wvalid)  wv_cyc++;
        if (!rst_n) begin
            prev_aw_pend = 1'b0; prev_w_pend = 1'b0;
        end else begin
            chk("awprot", 32'(awprot), 32'd0);
            if (q.size() > 0 && q[0].clip && awvalid) chk("clip_no_aw", 32'(awvalid), 32'd0);
            if (awvalid && awready) begin
                cap_awaddr = awaddr;
                if (q.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
                else chk("awaddr", awaddr, q[0].addr);
            end
            if (wvalid && wready) begin
                cap_wdata = wdata; cap_wstrb = wstrb;
                if (q.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
                else begin
                    chk("wdata", wdata, q[0].data);
                    chk("wstrb", 32'(wstrb), 32'(q[0].strb));
                end
            end
            if (prev_aw_pend) begin
                chk("awvalid_held", 32'(awvalid), 32'd1);
                chk("awaddr_stable", awaddr, prev_awaddr);
            end
            if (prev_w_pend) begin
                chk("wvalid_held", 32'(wvalid), 32'd1);
                chk("wdata_stable", wdata, prev_wdata);
            end
            if (done) begin
                if (q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    hd = q.pop_front();
                    if (hd.clip) m_clip = (m_clip < 255) ? m_clip + 1 : m_clip;
                    else begin
                        m_pix = (m_pix < 65535) ? m_pix + 1 : m_pix;
                        if (hd.br != 2'b00) m_err = (m_err < 255) ? m_err + 1 : m_err;
                    end
                    chk("state_at_done", 32'(state), 32'd0);
                end
            end
            chk("status", status, {16'(m_pix), 8'(m_clip), 8'(m_err)});
            prev_aw_pend = awvalid && !awready; prev_awaddr = awaddr;
            prev_w_pend  = wvalid && !wready;   prev_wdata  = wdata;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One pixel request; lat = cycle index (edge that sampled the request is 0) of writes_done.
    task automatic run_pixel(input int x, input int y, input logic [15:0] c, input int hold,
                             input int exp_lat, input string name);
        int lat = -1;
        fb_addr = {16'(x), 16'(y)}; fb_data = c;
        q.push_back(model(x, y, c, cur_bresp));
        awv_cyc = 0; wv_cyc = 0;
        w_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (k == hold - 1) w_en = 1'b0;
            if (done) begin lat = k + 1; break; end
        end
        chk(name, 32'(lat), 32'(exp_lat));
        if (w_en) begin w_en = 1'b0; tick(); end
    endtask

    int aw0, b0, lat;
    exp_t me;

    initial begin
        rst_n = 1'b0; w_en = 1'b0; fb_addr = '0; fb_data = '0;
        aw_delay = 0; cur_bresp = 2'b00; m_pix = 0; m_clip = 0; m_err = 0;
        repeat (2) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wstrb", 32'(wstrb), 32'd0);
        chk("rst_status", status, 32'd0);
        rst_n = 1'b1; tick();

        // Hand-computed pins of the model itself.
        me = model(3, 2, 16'hF800, 2'b00);
        chk("model_addr", me.addr, 32'h1000_140C);
        chk("model_red", me.data, 32'hFFFF_0000);
        me = model(5, 1, 16'h8410, 2'b00);
        chk("model_mid", me.data, 32'hFF84_8284);

        // Zero-wait slave.
        run_pixel(3, 2, 16'hF800, 1, 4, "lat_zero_wait");
        chk("t1_awaddr", cap_awaddr, 32'h1000_140C);
        chk("t1_wdata", cap_wdata, 32'hFFFF_0000);
        chk("t1_wstrb", 32'(cap_wstrb), 32'hF);
        chk("t1_pix", 32'(status[31:16]), 32'd1);

        // AWREADY three cycles late.
        aw_delay = 3; b0 = b_hs_cnt;
        run_pixel(10, 5, 16'h07E0, 1, 7, "lat_aw_slow");
        chk("t2_wvalid_cycles", 32'(wv_cyc), 32'd1);
        chk("t2_awvalid_cycles", 32'(awv_cyc), 32'd4);
        chk("t2_wdata", cap_wdata, 32'hFF00_FF00);
        chk("t2_b_count", 32'(b_hs_cnt - b0), 32'd1);
        aw_delay = 0;

        // Back-to-back: new edge in the same cycle writes_done is high.
        run_pixel(0, 0, 16'h001F, 1, 4, "lat_b2b_a");
        chk("b2b_a_data", cap_wdata, 32'hFF00_00FF);
        run_pixel(HR - 1, VR - 1, 16'hFFFF, 1, 4, "lat_b2b_b");
        chk("b2b_b_addr", cap_awaddr, 32'h1012_BFFC);
        chk("b2b_pix", status, {16'd4, 8'd0, 8'd0});

        // Clipped pixels on each axis boundary.
        aw0 = aw_hs_cnt;
        run_pixel(HR, 0, 16'h1234, 1, 2, "lat_clip_x");
        chk("clip_state", 32'(state), 32'd0);
        chk("clip1", status, {16'd4, 8'd1, 8'd0});
        run_pixel(0, VR, 16'h1234, 1, 2, "lat_clip_y");
        chk("clip2", status, {16'd4, 8'd2, 8'd0});
        chk("clip_no_aw_hs", 32'(aw_hs_cnt - aw0), 32'd0);

        // w_en held 4 cycles, then re-pulsed while in WRITE.
        aw_delay = 5; aw0 = aw_hs_cnt; b0 = b_hs_cnt; lat = -1;
        fb_addr = {16'd7, 16'd9}; fb_data = 16'h5555;
        q.push_back(model(7, 9, 16'h5555, cur_bresp));
        w_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (k == 3) w_en = 1'b0;
            if (k == 4) begin w_en = 1'b1; chk("hold_state_write", 32'(state), 32'd2); end
            if (done) begin lat = k + 1; break; end
        end
        chk("lat_hold", 32'(lat), 32'd9);
        w_en = 1'b0;
        repeat (6) tick();
        chk("hold_one_aw", 32'(aw_hs_cnt - aw0), 32'd1);
        chk("hold_one_b", 32'(b_hs_cnt - b0), 32'd1);
        chk("hold_pix", status, {16'd5, 8'd2, 8'd0});
        aw_delay = 0;

        // SLVERR response.
        cur_bresp = 2'b10;
        run_pixel(5, 1, 16'h8410, 1, 4, "lat_slverr");
        chk("err_state", 32'(state), 32'd0);
        chk("err_status", status, {16'd6, 8'd2, 8'd1});
        cur_bresp = 2'b00;

        // Reset while AWVALID is pending.
        aw_delay = 5; lat = -1;
        fb_addr = {16'd1, 16'd1}; fb_data = 16'hFFFF;
        q.push_back(model(1, 1, 16'hFFFF, cur_bresp));
        w_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            w_en = 1'b0;
            if (awvalid) begin lat = k; break; end
        end
        chk("rst_mid_reached_write", 32'(awvalid), 32'd1);
        rst_n = 1'b0;
        tick();
        q.delete(); m_pix = 0; m_clip = 0; m_err = 0;
        chk("mid_rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_status", status, 32'd0);
        rst_n = 1'b1; aw_delay = 0;
        tick();
        run_pixel(3, 2, 16'hF800, 1, 4, "lat_after_rst");
        chk("after_rst_status", status, {16'd1, 8'd0, 8'd0});
        repeat (3) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
